// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, ALU/mux encodings, state encoding and control bundle for the multi-cycle MIPS controller
package mips_ctrl_pkg;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_AND   = 3'b110;
  localparam logic [2:0] ALU_LUI   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b111;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R,
    S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP, S_FAULT
  } state_t;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_eq;
    logic       pc_write_ne;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal_op;
    logic       mem_fault;
  } ctrl_t;
  // S_FETCH doubles as the "unsupported opcode" marker
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:                     return S_MEM_ADDR;
      OP_R:                             return S_EXEC_R;
      OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: return S_EXEC_I;
      OP_BEQ, OP_BNE:                   return S_BRANCH;
      OP_J:                             return S_JUMP;
      default:                          return S_FETCH;
    endcase
  endfunction
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    return (op == OP_ORI) ? ALU_OR : (op == OP_ANDI) ? ALU_AND : (op == OP_LUI) ? ALU_LUI : ALU_ADD;
  endfunction
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled cycles of a memory request and flags when the wait budget is spent
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] cnt_q;
  assign expired_o = (cnt_q == W'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else if (clear_i) cnt_q <= '0;
    else if (inc_i && !expired_o) cnt_q <= cnt_q + W'(1);
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequencing control for the multi-cycle MIPS datapath with memory handshake and timeout fault
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT    = 16,
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_eq,
  output logic       pc_write_ne,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       illegal_op,
  output logic       mem_fault
);
  state_t state_q, state_d, stall_s, dec_s;
  logic   expired;
  ctrl_t  ctrl, out;
  assign dec_s = decode_next(opcode);
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (is_mem_state(state_d) && (state_d != state_q)),
    .inc_i    (is_mem_state(state_q) && !mem_ready),
    .expired_o(expired)
  );
  always_comb begin
    stall_s = (TIMEOUT_EN && expired) ? S_FAULT : state_q;
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : stall_s;
      S_DECODE:    state_d = dec_s;
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : stall_s;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : stall_s;
      S_EXEC_R:    state_d = S_R_WB;
      S_EXEC_I:    state_d = S_I_WB;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else state_q <= state_d;
  end
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = (dec_s == S_FETCH);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op(opcode);
      end
      S_I_WB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_B;
        ctrl.alu_op      = ALU_SUB;
        ctrl.pc_source   = PCSRC_ALUOUT;
        ctrl.pc_write_eq = (opcode == OP_BEQ);
        ctrl.pc_write_ne = (opcode == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_FAULT: ctrl.mem_fault = 1'b1;
      default: ctrl = '0;
    endcase
  end
  // gating by reset itself makes requests drop the instant reset asserts
  assign out         = reset ? ctrl : '0;
  assign pc_write    = out.pc_write;
  assign pc_write_eq = out.pc_write_eq;
  assign pc_write_ne = out.pc_write_ne;
  assign pc_source   = out.pc_source;
  assign i_or_d      = out.i_or_d;
  assign mem_read    = out.mem_read;
  assign mem_write   = out.mem_write;
  assign ir_write    = out.ir_write;
  assign mem_to_reg  = out.mem_to_reg;
  assign reg_dst     = out.reg_dst;
  assign reg_write   = out.reg_write;
  assign alu_src_a   = out.alu_src_a;
  assign alu_src_b   = out.alu_src_b;
  assign alu_op      = out.alu_op;
  assign illegal_op  = out.illegal_op;
  assign mem_fault   = out.mem_fault;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed per-cycle checks of the full control vector against hand-built expectations
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_fault;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;
  logic [19:0] obs;
  int vectors = 0;
  int errors = 0;
  // field order: pw peq pne psrc iord mr mw irw m2r rdst rw a b op ill flt
  localparam logic [19:0] ZERO    = 20'b0_0_0_00_0_0_0_0_0_0_0_0_00_000_0_0;
  localparam logic [19:0] F_STALL = 20'b0_0_0_00_0_1_0_0_0_0_0_0_01_100_0_0;
  localparam logic [19:0] F_RDY   = 20'b1_0_0_00_0_1_0_1_0_0_0_0_01_100_0_0;
  localparam logic [19:0] DEC     = 20'b0_0_0_00_0_0_0_0_0_0_0_0_11_100_0_0;
  localparam logic [19:0] DEC_ILL = 20'b0_0_0_00_0_0_0_0_0_0_0_0_11_100_1_0;
  localparam logic [19:0] MADDR   = 20'b0_0_0_00_0_0_0_0_0_0_0_1_10_100_0_0;
  localparam logic [19:0] MREAD   = 20'b0_0_0_00_1_1_0_0_0_0_0_0_00_000_0_0;
  localparam logic [19:0] MWB     = 20'b0_0_0_00_0_0_0_0_1_0_1_0_00_000_0_0;
  localparam logic [19:0] MWRITE  = 20'b0_0_0_00_1_0_1_0_0_0_0_0_00_000_0_0;
  localparam logic [19:0] EX_R    = 20'b0_0_0_00_0_0_0_0_0_0_0_1_00_111_0_0;
  localparam logic [19:0] R_WB    = 20'b0_0_0_00_0_0_0_0_0_1_1_0_00_000_0_0;
  localparam logic [19:0] EX_ADD  = 20'b0_0_0_00_0_0_0_0_0_0_0_1_10_100_0_0;
  localparam logic [19:0] EX_OR   = 20'b0_0_0_00_0_0_0_0_0_0_0_1_10_101_0_0;
  localparam logic [19:0] EX_LUI  = 20'b0_0_0_00_0_0_0_0_0_0_0_1_10_011_0_0;
  localparam logic [19:0] I_WB    = 20'b0_0_0_00_0_0_0_0_0_0_1_0_00_000_0_0;
  localparam logic [19:0] BR_EQ   = 20'b0_1_0_01_0_0_0_0_0_0_0_1_00_001_0_0;
  localparam logic [19:0] BR_NE   = 20'b0_0_1_01_0_0_0_0_0_0_0_1_00_001_0_0;
  localparam logic [19:0] JMP     = 20'b1_0_0_10_0_0_0_0_0_0_0_0_00_000_0_0;
  localparam logic [19:0] FAULT   = 20'b0_0_0_00_0_0_0_0_0_0_0_0_00_000_0_1;
  multicycle_control_fsm #(.TIMEOUT(16), .TIMEOUT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_op(illegal_op), .mem_fault(mem_fault)
  );
  assign obs = {pc_write, pc_write_eq, pc_write_ne, pc_source, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op, mem_fault};
  always #5 clk = ~clk;
  task automatic test_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = i[0]; #1;
      vectors++;
      if (obs !== ZERO) begin errors++; $display("FAIL reset cyc%0d: got %b want %b", i, obs, ZERO); end
    end
    @(negedge clk); mem_ready = 1'b0; reset = 1'b1;
  endtask
  task automatic test_itype();
    logic [19:0] e [15] = '{F_RDY, DEC, EX_ADD, I_WB, F_STALL, F_RDY, DEC, EX_OR, I_WB, F_STALL,
                            F_RDY, DEC, EX_LUI, I_WB, F_STALL};
    logic [5:0]  o [15] = '{6'h08, 6'h08, 6'h08, 6'h08, 6'h08, 6'h0D, 6'h0D, 6'h0D, 6'h0D, 6'h0D,
                            6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); opcode = o[i]; mem_ready = (i % 5 != 4); #1;
      vectors++;
      if (obs !== e[i]) begin errors++; $display("FAIL itype step%0d: got %b want %b", i, obs, e[i]); end
    end
  endtask
  task automatic test_lw_wait();
    logic [19:0] e [9] = '{F_RDY, DEC, MADDR, MREAD, MREAD, MREAD, MREAD, MWB, F_STALL};
    bit          r [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    opcode = 6'h23;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); mem_ready = r[i]; #1;
      vectors++;
      if (obs !== e[i]) begin errors++; $display("FAIL lw step%0d: got %b want %b", i, obs, e[i]); end
    end
  endtask
  task automatic test_branch();
    logic [19:0] e [8] = '{F_RDY, DEC, BR_EQ, F_STALL, F_RDY, DEC, BR_NE, F_STALL};
    logic [5:0]  o [8] = '{6'h04, 6'h04, 6'h04, 6'h04, 6'h05, 6'h05, 6'h05, 6'h05};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); opcode = o[i]; mem_ready = (i % 4 != 3); #1;
      vectors++;
      if (obs !== e[i]) begin errors++; $display("FAIL branch step%0d: got %b want %b", i, obs, e[i]); end
    end
  endtask
  task automatic test_rtype_jump();
    logic [19:0] e [9] = '{F_RDY, DEC, EX_R, R_WB, F_STALL, F_RDY, DEC, JMP, F_STALL};
    logic [5:0]  o [9] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h02, 6'h02, 6'h02};
    bit          r [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); opcode = o[i]; mem_ready = r[i]; #1;
      vectors++;
      if (obs !== e[i]) begin errors++; $display("FAIL rj step%0d: got %b want %b", i, obs, e[i]); end
    end
  endtask
  task automatic test_illegal();
    logic [19:0] e [3] = '{F_RDY, DEC_ILL, F_STALL};
    bit          r [3] = '{1'b1, 1'b1, 1'b0};
    opcode = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = r[i]; #1;
      vectors++;
      if (obs !== e[i]) begin errors++; $display("FAIL illegal step%0d: got %b want %b", i, obs, e[i]); end
    end
  endtask
  task automatic test_timeout_edge();
    logic [19:0] e[$];
    bit          r[$];
    e = '{F_RDY, DEC, MADDR};
    r = '{1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 16; i++) begin e.push_back(MWRITE); r.push_back(i == 15); end
    e.push_back(F_STALL); r.push_back(1'b0);
    opcode = 6'h2B;
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk); mem_ready = r[i]; #1;
      vectors++;
      if (obs !== e[i]) begin errors++; $display("FAIL to_edge step%0d: got %b want %b", i, obs, e[i]); end
    end
  endtask
  task automatic test_reset_mid_write();
    logic [19:0] e [5] = '{F_RDY, DEC, MADDR, MWRITE, MWRITE};
    bit          r [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    opcode = 6'h2B;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ready = r[i]; #1;
      vectors++;
      if (obs !== e[i]) begin errors++; $display("FAIL midrst step%0d: got %b want %b", i, obs, e[i]); end
    end
    #1 reset = 1'b0;
    #1 vectors++;
    if (mem_write !== 1'b0) begin errors++; $display("FAIL midrst async_drop: got mem_write=%b want 0", mem_write); end
    @(negedge clk); #1 vectors++;
    if (obs !== ZERO) begin errors++; $display("FAIL midrst held: got %b want %b", obs, ZERO); end
    reset = 1'b1;
    @(negedge clk); #1 vectors++;
    if (obs !== F_STALL) begin errors++; $display("FAIL midrst restart: got %b want %b", obs, F_STALL); end
  endtask
  task automatic test_timeout_fault();
    logic [19:0] e[$];
    bit          r[$];
    e = '{F_RDY, DEC, MADDR};
    r = '{1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 16; i++) begin e.push_back(MWRITE); r.push_back(1'b0); end
    for (int i = 0; i < 4; i++) begin e.push_back(FAULT); r.push_back(i[0] == 1'b0); end
    opcode = 6'h2B;
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk); mem_ready = r[i]; #1;
      vectors++;
      if (obs !== e[i]) begin errors++; $display("FAIL fault step%0d: got %b want %b", i, obs, e[i]); end
    end
    @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
    vectors++;
    if (obs !== ZERO) begin errors++; $display("FAIL fault in_reset: got %b want %b", obs, ZERO); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1 vectors++;
    if (obs !== F_STALL) begin errors++; $display("FAIL fault cleared: got %b want %b", obs, F_STALL); end
  endtask
  initial begin
    test_reset();
    test_itype();
    test_lw_wait();
    test_branch();
    test_rtype_jump();
    test_illegal();
    test_timeout_edge();
    test_reset_mid_write();
    test_timeout_fault();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
